// File: rtl/vc_fifo_multi.sv
// vc_fifo_multi: NUM_VC independent circular FIFOs behind a shared write port and a shared read port.
// Ports:
//   clk, reset (sync, active-low), init (sync, active-low soft init, same effect as reset)
//   wr_enable/wr_vc/data_in    : write request into channel wr_vc
//   rd_enable/rd_vc            : read request from channel rd_vc
//   umbral                     : per-channel threshold, ADDR_WIDTH bits per channel
//   full/empty/almost_full/almost_empty : per-channel occupancy flags, combinational from cnt
//   error                      : sticky per-channel overflow/underflow
//   sel_error                  : sticky out-of-range channel request
//   data_out/valid_out/vc_out  : registered read data, strobe and source channel
module vc_fifo_multi #(
  parameter int DATA_WIDTH   = 6,
  parameter int ADDR_WIDTH   = 4,
  parameter int NUM_VC       = 2,
  parameter int VC_SEL_WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         init,
  input  logic                         wr_enable,
  input  logic [VC_SEL_WIDTH-1:0]      wr_vc,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         rd_enable,
  input  logic [VC_SEL_WIDTH-1:0]      rd_vc,
  input  logic [NUM_VC*ADDR_WIDTH-1:0] umbral,
  output logic [NUM_VC-1:0]            full,
  output logic [NUM_VC-1:0]            empty,
  output logic [NUM_VC-1:0]            almost_full,
  output logic [NUM_VC-1:0]            almost_empty,
  output logic [NUM_VC-1:0]            error,
  output logic                         sel_error,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  output logic [VC_SEL_WIDTH-1:0]      vc_out
);
  localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [VC_SEL_WIDTH:0] NVC   = (VC_SEL_WIDTH+1)'(NUM_VC);
  logic [DATA_WIDTH-1:0]   mem_q    [NUM_VC][2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr_q [NUM_VC];
  logic [ADDR_WIDTH-1:0]   wr_ptr_d [NUM_VC];
  logic [ADDR_WIDTH-1:0]   rd_ptr_q [NUM_VC];
  logic [ADDR_WIDTH-1:0]   rd_ptr_d [NUM_VC];
  logic [ADDR_WIDTH:0]     cnt_q    [NUM_VC];
  logic [ADDR_WIDTH:0]     cnt_d    [NUM_VC];
  logic [NUM_VC-1:0]       error_q, error_d;
  logic                    sel_error_q, sel_error_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    valid_out_q, valid_out_d;
  logic [VC_SEL_WIDTH-1:0] vc_out_q, vc_out_d;
  logic [NUM_VC-1:0]       wr_sel, rd_sel, wr_ok, rd_ok;
  logic [ADDR_WIDTH-1:0]   thr;
  logic                    clr;
  assign clr = !reset || !init;
  // umbral==0 needs no special case: cnt>=DEPTH implies full, cnt<=0 implies empty
  always_comb begin
    thr = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      thr             = umbral[k*ADDR_WIDTH +: ADDR_WIDTH];
      full[k]         = cnt_q[k] == DEPTH;
      empty[k]        = cnt_q[k] == '0;
      almost_full[k]  = !full[k] && cnt_q[k] >= DEPTH - {1'b0, thr};
      almost_empty[k] = !empty[k] && cnt_q[k] <= {1'b0, thr};
    end
  end
  // Per-channel decode keeps out-of-range selects from ever indexing the arrays
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    error_d     = error_q;
    data_out_d  = '0;
    wr_sel      = '0;
    rd_sel      = '0;
    wr_ok       = '0;
    rd_ok       = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      wr_sel[k]   = wr_enable && wr_vc == VC_SEL_WIDTH'(k);
      rd_sel[k]   = rd_enable && rd_vc == VC_SEL_WIDTH'(k);
      rd_ok[k]    = rd_sel[k] && !empty[k];
      // a same-channel read frees a slot, so a full channel can still take the write
      wr_ok[k]    = wr_sel[k] && (!full[k] || rd_ok[k]);
      wr_ptr_d[k] = wr_ok[k] ? wr_ptr_q[k] + 1'b1 : wr_ptr_q[k];
      rd_ptr_d[k] = rd_ok[k] ? rd_ptr_q[k] + 1'b1 : rd_ptr_q[k];
      cnt_d[k]    = cnt_q[k] + (ADDR_WIDTH+1)'(wr_ok[k]) - (ADDR_WIDTH+1)'(rd_ok[k]);
      error_d[k]  = error_q[k] || (wr_sel[k] && !wr_ok[k]) || (rd_sel[k] && !rd_ok[k]);
      data_out_d  = rd_ok[k] ? mem_q[k][rd_ptr_q[k]] : data_out_d;
    end
    sel_error_d = sel_error_q || (wr_enable && {1'b0, wr_vc} >= NVC) || (rd_enable && {1'b0, rd_vc} >= NVC);
    valid_out_d = |rd_ok;
    vc_out_d    = valid_out_d ? rd_vc : vc_out_q;
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_VC; k++)
      if (wr_ok[k] && !clr) mem_q[k][wr_ptr_q[k]] <= data_in;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q    <= '{default: '0};
      rd_ptr_q    <= '{default: '0};
      cnt_q       <= '{default: '0};
      error_q     <= '0;
      sel_error_q <= 1'b0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      vc_out_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      error_q     <= error_d;
      sel_error_q <= sel_error_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      vc_out_q    <= vc_out_d;
    end
  end
  assign error     = error_q;
  assign sel_error = sel_error_q;
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign vc_out    = vc_out_q;
endmodule

// File: tb/tb_vc_fifo_multi.sv
// tb_vc_fifo_multi: directed self-checking bench for vc_fifo_multi (2-bit channel select so index 2 is reachable)
module tb_vc_fifo_multi;
  logic       clk = 1'b0;
  logic       reset, init, wr_enable, rd_enable;
  logic [1:0] wr_vc, rd_vc, vc_out;
  logic [5:0] data_in, data_out;
  logic [7:0] umbral;
  logic [1:0] full, empty, almost_full, almost_empty, error;
  logic       sel_error, valid_out;
  int         checks = 0, failures = 0;
  logic [5:0] q0[$], q1[$];
  always #5 clk = ~clk;
  vc_fifo_multi #(.DATA_WIDTH(6), .ADDR_WIDTH(4), .NUM_VC(2), .VC_SEL_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .init(init), .wr_enable(wr_enable), .wr_vc(wr_vc),
    .data_in(data_in), .rd_enable(rd_enable), .rd_vc(rd_vc), .umbral(umbral),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .error(error), .sel_error(sel_error), .data_out(data_out), .valid_out(valid_out),
    .vc_out(vc_out)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic we, input logic [1:0] wv, input logic [5:0] d, input logic re, input logic [1:0] rv);
    wr_enable = we; wr_vc = wv; data_in = d; rd_enable = re; rd_vc = rv;
    @(posedge clk); #1;
    wr_enable = 1'b0; rd_enable = 1'b0;
  endtask
  task automatic rst_pulse();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask
  initial begin
    logic [1:0] wv, rv;
    logic [5:0] d, e;
    logic       re;
    reset = 1'b0; init = 1'b1; wr_enable = 1'b0; rd_enable = 1'b0;
    wr_vc = '0; rd_vc = '0; data_in = '0; umbral = 8'h44;
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    check("rst_empty", empty, 2'b11);
    check("rst_full", full, 2'b00);
    check("rst_af", almost_full, 2'b00);
    check("rst_ae", almost_empty, 2'b00);
    check("rst_err", error, 2'b00);
    check("rst_sel", sel_error, 1'b0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_data", data_out, 6'h00);
    check("rst_vc", vc_out, 2'd0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 2'd0, 6'(i), 1'b0, 2'd0);
      check("fill_af", almost_full[0], i >= 12 && i < 16);
      check("fill_ae", almost_empty[0], i <= 4);
      check("fill_full", full[0], i == 16);
    end
    check("fill_vc1_empty", empty[1], 1'b1);
    check("fill_idle_valid", valid_out, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 2'd0, 6'h00, 1'b1, 2'd0);
      check("drain_valid", valid_out, 1'b1);
      check("drain_data", data_out, 6'(i));
      check("drain_vc", vc_out, 2'd0);
    end
    cyc(1'b0, 2'd0, 6'h00, 1'b0, 2'd0);
    check("drain_idle_valid", valid_out, 1'b0);
    check("drain_idle_data", data_out, 6'h00);
    check("drain_empty", empty, 2'b11);
    check("drain_err", error, 2'b00);
    for (int i = 1; i <= 16; i++) cyc(1'b1, 2'd1, 6'(8'h20 + i), 1'b0, 2'd0);
    check("ovf_full", full, 2'b10);
    cyc(1'b1, 2'd1, 6'h3F, 1'b0, 2'd0);
    check("ovf_err", error, 2'b10);
    check("ovf_full_keep", full, 2'b10);
    cyc(1'b0, 2'd0, 6'h00, 1'b1, 2'd0);
    check("udf_err", error, 2'b11);
    check("udf_valid", valid_out, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 2'd0, 6'h00, 1'b1, 2'd1);
      check("ovf_data", data_out, 6'(8'h20 + i));
      check("ovf_vc", vc_out, 2'd1);
    end
    cyc(1'b0, 2'd0, 6'h00, 1'b0, 2'd0);
    check("vc_hold", vc_out, 2'd1);
    check("ovf_empty", empty, 2'b11);
    check("err_sticky", error, 2'b11);
    rst_pulse();
    check("err_cleared", error, 2'b00);
    for (int i = 1; i <= 16; i++) cyc(1'b1, 2'd0, 6'(i), 1'b0, 2'd0);
    cyc(1'b1, 2'd0, 6'h2A, 1'b1, 2'd0);
    check("sim_valid", valid_out, 1'b1);
    check("sim_data", data_out, 6'h01);
    check("sim_full", full[0], 1'b1);
    check("sim_err", error, 2'b00);
    for (int i = 2; i <= 16; i++) begin
      cyc(1'b0, 2'd0, 6'h00, 1'b1, 2'd0);
      check("sim_drain", data_out, 6'(i));
    end
    cyc(1'b0, 2'd0, 6'h00, 1'b1, 2'd0);
    check("sim_last", data_out, 6'h2A);
    check("sim_empty", empty[0], 1'b1);
    cyc(1'b1, 2'd1, 6'h15, 1'b1, 2'd1);
    check("byp_valid", valid_out, 1'b0);
    check("byp_err", error, 2'b10);
    check("byp_empty", empty[1], 1'b0);
    check("byp_ae", almost_empty[1], 1'b1);
    cyc(1'b0, 2'd0, 6'h00, 1'b1, 2'd1);
    check("byp_data", data_out, 6'h15);
    rst_pulse();
    for (int t = 0; t < 40; t++) begin
      wv = 2'(t % 2);
      rv = wv ^ 2'd1;
      d  = 6'(t * 3 + 5);
      e  = 6'h00;
      re = (rv == 2'd0) ? q0.size() > 0 : q1.size() > 0;
      if (re) begin
        if (rv == 2'd0) e = q0.pop_front();
        else e = q1.pop_front();
      end
      cyc(1'b1, wv, d, re, rv);
      if (wv == 2'd0) q0.push_back(d);
      else q1.push_back(d);
      check("x_valid", valid_out, re);
      if (re) begin
        check("x_data", data_out, e);
        check("x_vc", vc_out, rv);
      end
    end
    while (q1.size() > 0) begin
      e = q1.pop_front();
      cyc(1'b0, 2'd0, 6'h00, 1'b1, 2'd1);
      check("x_tail", data_out, e);
    end
    check("x_empty", empty, 2'b11);
    check("x_err", error, 2'b00);
    cyc(1'b1, 2'd2, 6'h11, 1'b0, 2'd0);
    check("sel_err", sel_error, 1'b1);
    check("sel_ignored", empty, 2'b11);
    cyc(1'b0, 2'd0, 6'h00, 1'b1, 2'd3);
    check("sel_rd_valid", valid_out, 1'b0);
    check("sel_no_err", error, 2'b00);
    for (int i = 1; i <= 5; i++) cyc(1'b1, 2'd0, 6'(i), 1'b0, 2'd0);
    check("init_pre", empty, 2'b10);
    init = 1'b0;
    cyc(1'b0, 2'd0, 6'h00, 1'b1, 2'd0);
    init = 1'b1;
    check("init_empty", empty, 2'b11);
    check("init_valid", valid_out, 1'b0);
    check("init_sel", sel_error, 1'b0);
    umbral = 8'h00;
    cyc(1'b1, 2'd1, 6'h07, 1'b0, 2'd0);
    check("u0_ae", almost_empty, 2'b00);
    check("u0_empty", empty, 2'b01);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vc_fifo_multi.md
Name: vc_fifo_multi

Overview:
- Parametrised multi-virtual-channel FIFO bank for the PCIe transmission-layer datapath: NUM_VC independent circular FIFOs behind one shared write port and one shared read port, each addressed by a channel select.
- Successor to the single-channel VC FIFO. It adds:
  - per-VC programmable thresholds with inequality flags;
  - simultaneous read+write, including on a full FIFO;
  - sticky overflow/underflow errors;
  - registered read data with a valid strobe and channel tag.
- Sits between the transaction-layer splitter (write side) and the arbiter/serializer (read side).

Parameters:
- DATA_WIDTH, 6, width of each entry.
- ADDR_WIDTH, 4, per-VC depth DEPTH = 2**ADDR_WIDTH.
- NUM_VC, 2, number of virtual channels (1..2**VC_SEL_WIDTH).
- VC_SEL_WIDTH, 1, width of channel-select fields.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- init  in  1  synchronous, active-low soft init; same effect as reset.
- wr_enable  in  1  write request.
- wr_vc  in  VC_SEL_WIDTH  target VC of write.
- data_in  in  DATA_WIDTH  write data.
- rd_enable  in  1  read request.
- rd_vc  in  VC_SEL_WIDTH  source VC of read.
- umbral  in  NUM_VC*ADDR_WIDTH  per-VC threshold; VC k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- full  out  NUM_VC  cnt[k]==DEPTH.
- empty  out  NUM_VC  cnt[k]==0.
- almost_full  out  NUM_VC  cnt[k] >= DEPTH-umbral[k] and not full.
- almost_empty  out  NUM_VC  cnt[k] <= umbral[k] and not empty.
- error  out  NUM_VC  sticky overflow/underflow per VC.
- sel_error  out  1  sticky: request to VC index >= NUM_VC.
- data_out  out  DATA_WIDTH  registered read data.
- valid_out  out  1  data_out valid this cycle.
- vc_out  out  VC_SEL_WIDTH  VC that produced data_out.

Behaviour:
- Reset/init:
  - While reset==0 or init==0 at a clock edge, all per-VC wr_ptr, rd_ptr and cnt (ADDR_WIDTH+1 bits) clear to 0.
  - error=0, sel_error=0, data_out=0, valid_out=0, vc_out=0.
  - Memory contents are not cleared (don't-care).
  - Assertion mid-operation discards all queued data the next edge; any accepted read in flight is lost (valid_out=0).
- Flags: full, empty, almost_full and almost_empty are combinational from cnt and umbral. They update the cycle after the causing edge.
- Write accepted when all of the following hold:
  - wr_enable;
  - wr_vc < NUM_VC;
  - full[wr_vc]==0, OR a read is accepted from the same VC in the same cycle.
- Accepted write: mem[wr_vc][wr_ptr] <= data_in, and wr_ptr increments modulo DEPTH (natural wrap).
- Read accepted when rd_enable, rd_vc < NUM_VC and empty[rd_vc]==0.
  - No empty bypass: a read and write to the same empty VC in the same cycle accepts only the write.
- Accepted read:
  - data_out <= mem[rd_vc][rd_ptr], valid_out <= 1, vc_out <= rd_vc.
  - rd_ptr increments modulo DEPTH.
  - Latency 1 cycle from request edge to valid_out high.
- No accepted read: data_out <= 0, valid_out <= 0, vc_out holds.
- cnt update per VC k:
  - +1 if only a write to k is accepted;
  - -1 if only a read from k is accepted;
  - unchanged if both or neither.
- Writes and reads to different VCs are fully independent in the same cycle.
- Errors are sticky until reset/init:
  - Rejected write to a full VC (no same-VC read) sets error[wr_vc]; data is dropped and pointers are unchanged.
  - Rejected read from an empty VC sets error[rd_vc].
  - Out-of-range wr_vc or rd_vc with its enable set sets sel_error; that request is ignored.
- Invariant: cnt[k] never exceeds DEPTH or wraps below 0.
- umbral==0 boundary: almost_full and almost_empty never assert.

Test Plan:
- Reset then fill: write 16 words 0x01..0x10 to VC0, rd idle -> full[0]=1 after 16th edge. almost_full[0]=1 from cnt=12 to 15 with umbral[0]=4. VC1 flags unchanged (empty[1]=1).
- Drain with order and latency: read VC0 16 times -> valid_out one cycle after each request, data 0x01..0x10 in order, vc_out=0. empty[0]=1 at end, error[0]=0.
- Overflow/underflow: write 17th word to full VC1 -> error[1]=1, contents unchanged. Read empty VC0 -> error[0]=1, valid_out=0. Both errors persist until reset pulse.
- Simultaneous access:
  - full VC0, write 0x2A and read VC0 same cycle -> both accepted, cnt stays 16, 0x2A read out last.
  - empty VC1, write+read VC1 -> write only, cnt=1, error[1]=1.
- Cross-channel and wrap: interleave writes to VC0/VC1 while reading the other across 40 cycles -> per-VC FIFO order preserved through pointer wrap.
- Mid-operation control: wr_vc=2 with NUM_VC=2 -> sel_error=1, ignored. init low for 1 cycle with 5 entries queued -> all empty=1, valid_out=0 next cycle.
